// File: rtl/apb_arbiter_master_if.sv
// apb_arbiter_master_if: APB bus between the arbitrating master and a single slave
interface apb_arbiter_master_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] pwdata;
    logic [2:0]        prot;
    logic              pready;
    logic              pslverr;
    logic [DATA_W-1:0] prdata;

    modport master (
        output psel, penable, pwrite, addr, pwdata, prot,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  psel, penable, pwrite, addr, pwdata, prot,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/apb_arbiter_master.sv
// apb_arbiter_master: round-robin two-requester APB master with wait-state timeout
module apb_arbiter_master #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              r0_valid,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic [2:0]        r0_prot,
    output logic              r0_ack,
    output logic              r0_done,
    input  logic              r1_valid,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic [2:0]        r1_prot,
    output logic              r1_ack,
    output logic              r1_done,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_slverr,
    apb_arbiter_master_if.master bus
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          state;
    logic            last;
    logic            owner;
    logic            win;
    logic            expire;
    logic [CW-1:0]   cnt;

    always_comb begin
        win    = (r0_valid && r1_valid) ? !last : r1_valid;
        expire = (TIMEOUT > 0) && (cnt == CW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            last        <= 1'b1;
            owner       <= 1'b0;
            cnt         <= '0;
            bus.psel    <= 1'b0;
            bus.penable <= 1'b0;
            bus.pwrite  <= 1'b0;
            bus.addr    <= '0;
            bus.pwdata  <= '0;
            bus.prot    <= '0;
            r0_ack      <= 1'b0;
            r1_ack      <= 1'b0;
            r0_done     <= 1'b0;
            r1_done     <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
        end else begin
            r0_ack  <= 1'b0;
            r1_ack  <= 1'b0;
            r0_done <= 1'b0;
            r1_done <= 1'b0;
            case (state)
                IDLE: if (r0_valid || r1_valid) begin
                    state       <= SETUP;
                    owner       <= win;
                    last        <= win;
                    bus.psel    <= 1'b1;
                    bus.penable <= 1'b0;
                    bus.pwrite  <= win ? r1_write : r0_write;
                    bus.addr    <= win ? r1_addr : r0_addr;
                    bus.pwdata  <= win ? r1_wdata : r0_wdata;
                    bus.prot    <= win ? r1_prot : r0_prot;
                    r0_ack      <= !win;
                    r1_ack      <= win;
                end
                SETUP: begin
                    state       <= ACCESS;
                    bus.penable <= 1'b1;
                    cnt         <= '0;
                end
                ACCESS: if (bus.pready || expire) begin
                    state       <= IDLE;
                    bus.psel    <= 1'b0;
                    bus.penable <= 1'b0;
                    r0_done     <= !owner;
                    r1_done     <= owner;
                    rsp_slverr  <= bus.pready ? bus.pslverr : 1'b1;
                    rsp_rdata   <= (bus.pready && !bus.pwrite) ? bus.prdata : '0;
                end else if (cnt != '1) begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_arbiter_master.sv
// tb_apb_arbiter_master: directed and randomized checks against a transaction-level model
module tb_apb_arbiter_master;
    logic        clk = 1'b0;
    logic        resetn;
    logic        r0_valid, r0_write, r0_ack, r0_done;
    logic [4:0]  r0_addr;
    logic [31:0] r0_wdata;
    logic [2:0]  r0_prot;
    logic        r1_valid, r1_write, r1_ack, r1_done;
    logic [4:0]  r1_addr;
    logic [31:0] r1_wdata;
    logic [2:0]  r1_prot;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    int          passed = 0, failed = 0, total = 0;

    typedef struct {
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
        logic [2:0]  p;
    } cmd_t;

    cmd_t pend[2];
    bit   has[2];
    bit   mlast;

    apb_arbiter_master_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    apb_arbiter_master #(.ADDR_W(5), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .resetn(resetn),
        .r0_valid(r0_valid), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_prot(r0_prot), .r0_ack(r0_ack), .r0_done(r0_done),
        .r1_valid(r1_valid), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_prot(r1_prot), .r1_ack(r1_ack), .r1_done(r1_done),
        .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t new_cmd();
        cmd_t c;
        c.w = 1'($urandom_range(0, 1));
        c.a = 5'($urandom);
        c.d = $urandom;
        c.p = 3'($urandom);
        return c;
    endfunction

    task automatic drive_req;
        r0_valid = has[0]; r0_write = pend[0].w; r0_addr = pend[0].a;
        r0_wdata = pend[0].d; r0_prot = pend[0].p;
        r1_valid = has[1]; r1_write = pend[1].w; r1_addr = pend[1].a;
        r1_wdata = pend[1].d; r1_prot = pend[1].p;
    endtask

    task automatic do_reset;
        has[0] = 0; has[1] = 0;
        pend[0] = '{w: 0, a: 0, d: 0, p: 0};
        pend[1] = '{w: 0, a: 0, d: 0, p: 0};
        drive_req();
        bus.pready = 0; bus.pslverr = 0; bus.prdata = 0;
        resetn = 0;
        tick(); tick();
        resetn = 1;
    endtask

    initial begin
        int n;
        do_reset();
        chk("reset_psel", bus.psel, 0);
        chk("reset_penable", bus.penable, 0);
        chk("reset_ack", {r1_ack, r0_ack}, 0);
        chk("reset_done", {r1_done, r0_done}, 0);
        chk("reset_rsp", {rsp_slverr, rsp_rdata}, 0);
        chk("reset_addr", {bus.pwrite, bus.addr, bus.pwdata, bus.prot}, 0);

        // Zero-wait write from r0; pready high already during SETUP must be ignored
        has[0] = 1; pend[0] = '{w: 1, a: 5'd1, d: 32'hDEADBEEF, p: 3'd0};
        drive_req();
        bus.pready = 1; bus.prdata = 32'h5555AAAA;
        tick();
        chk("w_ack", {r1_ack, r0_ack}, 2'b01);
        chk("w_setup", {bus.psel, bus.penable}, 2'b10);
        chk("w_fields", {bus.pwrite, bus.addr, bus.pwdata}, {1'b1, 5'd1, 32'hDEADBEEF});
        has[0] = 0; drive_req();
        tick();
        chk("w_access", {bus.psel, bus.penable, r0_ack}, 3'b110);
        tick();
        chk("w_done", {r1_done, r0_done, bus.psel, bus.penable}, 4'b0100);
        chk("w_rsp", {rsp_slverr, rsp_rdata}, 0);
        tick();
        chk("w_done_pulse", r0_done, 0);

        // Continuous reads from both: grants alternate, one transfer per 3 cycles
        do_reset();
        has[0] = 1; has[1] = 1;
        pend[0] = '{w: 0, a: 5'd2, d: 0, p: 3'd1};
        pend[1] = '{w: 0, a: 5'd3, d: 0, p: 3'd2};
        drive_req();
        bus.pready = 1;
        for (int g = 0; g < 4; g++) begin
            bus.prdata = 32'h100 + g;
            tick();
            chk("rr_ack", {r1_ack, r0_ack}, (g % 2) ? 2'b10 : 2'b01);
            chk("rr_addr", bus.addr, (g % 2) ? 5'd3 : 5'd2);
            tick(); tick();
            chk("rr_done", {r1_done, r0_done}, (g % 2) ? 2'b10 : 2'b01);
            chk("rr_rdata", rsp_rdata, 32'h100 + g);
        end
        has[0] = 0; has[1] = 0; drive_req();
        tick();

        // r1 read with two wait states
        has[1] = 1; pend[1] = '{w: 0, a: 5'd1, d: 0, p: 3'd0};
        drive_req();
        bus.pready = 0; bus.prdata = 32'h12345678;
        tick();
        chk("ws_ack", r1_ack, 1);
        has[1] = 0; drive_req();
        n = 0;
        for (int i = 0; i < 40 && !r1_done; i++) begin
            tick();
            if (bus.penable) n++;
            bus.pready = (n >= 3);
        end
        chk("ws_done", r1_done, 1);
        chk("ws_penable_cycles", n, 3);
        chk("ws_rdata", rsp_rdata, 32'h12345678);

        // r0 read timing out with pready held low
        has[0] = 1; pend[0] = '{w: 0, a: 5'd4, d: 0, p: 3'd0};
        drive_req();
        bus.pready = 0; bus.prdata = 32'hAAAA5555;
        tick();
        has[0] = 0; drive_req();
        n = 0;
        for (int i = 0; i < 60 && !r0_done; i++) begin
            tick();
            if (bus.penable) n++;
        end
        chk("to_done", r0_done, 1);
        chk("to_cycles", n, 16);
        chk("to_rsp", {rsp_slverr, rsp_rdata}, {1'b1, 32'h0});
        chk("to_psel", {bus.psel, bus.penable}, 0);

        // slave error then clean transfer
        has[1] = 1; pend[1] = '{w: 1, a: 5'd7, d: 32'h0BAD0BAD, p: 3'd3};
        drive_req();
        bus.pready = 1; bus.pslverr = 1;
        tick();
        has[1] = 0; drive_req();
        tick(); tick();
        chk("err_done", {r1_done, rsp_slverr}, 2'b11);
        chk("err_prot", bus.prot, 3'd3);
        has[0] = 1; pend[0] = '{w: 1, a: 5'd8, d: 32'h1, p: 3'd0};
        drive_req();
        bus.pslverr = 0;
        tick();
        has[0] = 0; drive_req();
        tick(); tick();
        chk("err_clear", {r0_done, rsp_slverr}, 2'b10);

        // Reset during ACCESS aborts silently and restores round-robin start
        has[1] = 1; pend[1] = '{w: 0, a: 5'd9, d: 0, p: 3'd0};
        drive_req();
        bus.pready = 0;
        tick();
        has[1] = 0; drive_req();
        tick(); tick();
        chk("mid_access", {bus.psel, bus.penable}, 2'b11);
        resetn = 0;
        tick();
        chk("mid_reset_bus", {bus.psel, bus.penable}, 0);
        chk("mid_reset_done", {r1_done, r0_done}, 0);
        resetn = 1;
        tick();
        chk("mid_reset_nodone", {r1_done, r0_done}, 0);
        has[0] = 1; has[1] = 1; drive_req();
        tick();
        chk("mid_reset_rr", {r1_ack, r0_ack}, 2'b01);

        // Randomized traffic against a transaction-level model
        do_reset();
        mlast = 1;
        for (int k = 0; k < 40; k++) begin
            bit          win, tmo;
            int          lat, exp_pen;
            logic        err;
            logic [31:0] rd;
            for (int j = 0; j < 2; j++)
                if (!has[j] && $urandom_range(0, 2) != 0) begin
                    has[j] = 1; pend[j] = new_cmd();
                end
            if (!has[0] && !has[1]) begin
                has[k % 2] = 1; pend[k % 2] = new_cmd();
            end
            win     = (has[0] && has[1]) ? !mlast : has[1];
            mlast   = win;
            lat     = ($urandom_range(0, 7) == 0) ? 40 : $urandom_range(0, 3);
            tmo     = lat >= 16;
            exp_pen = tmo ? 16 : lat + 1;
            err     = 1'($urandom_range(0, 1));
            rd      = $urandom;
            drive_req();
            bus.pready = 0; bus.pslverr = err; bus.prdata = rd;
            tick();
            chk("rnd_ack", {r1_ack, r0_ack}, win ? 2'b10 : 2'b01);
            chk("rnd_setup", {bus.psel, bus.penable}, 2'b10);
            chk("rnd_fields", {bus.pwrite, bus.addr, bus.pwdata, bus.prot},
                {pend[win].w, pend[win].a, pend[win].d, pend[win].p});
            has[win] = 0; drive_req();
            n = 0;
            for (int i = 0; i < 60 && !(r0_done || r1_done); i++) begin
                tick();
                if (bus.penable) n++;
                bus.pready = (n >= lat + 1);
            end
            chk("rnd_done", {r1_done, r0_done}, win ? 2'b10 : 2'b01);
            chk("rnd_cycles", n, exp_pen);
            chk("rnd_slverr", rsp_slverr, tmo ? 1'b1 : err);
            chk("rnd_rdata", rsp_rdata, (tmo || pend[win].w) ? 32'h0 : rd);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
